// File: rtl/fp_final_reduce.sv
// ============================================================================
// Module   : fp_final_reduce
// Brief    : Canonical reduction of a wide unsigned value into [0, MOD) by
//            multi-cycle restoring shift-subtract, valid/ready on both sides.
//            Optional macro FINAL_REDUCE_UNROLL2_EN: two chained steps per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_final_reduce #(
    parameter int             W_IN = 262,
    parameter int             W_P  = 254,
    parameter logic [W_P-1:0] MOD  = 254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_IN-1:0] din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W_P-1:0]  dout
);

    localparam int K  = W_IN - W_P;
    localparam int KW = (K > 0) ? $clog2(K + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W_IN:0]   r_q, r_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W_P-1:0]  dout_q, dout_d;

    // One restoring step: subtract MOD<<k only if the result stays non-negative.
    function automatic logic [W_IN:0] reduce_step(input logic [W_IN:0] r,
                                                   input logic [KW-1:0] k);
        logic [W_IN:0] m;
        logic [W_IN:0] t;
        m = {{(W_IN + 1 - W_P){1'b0}}, MOD} << k;
        t = r - m;
        return t[W_IN] ? r : t;
    endfunction

`ifdef FINAL_REDUCE_UNROLL2_EN
    logic [W_IN:0] w_r1;
    assign w_r1 = reduce_step(r_q, k_q);
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d     = {1'b0, din};
                    k_d     = KW'(K);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef FINAL_REDUCE_UNROLL2_EN
                // With an odd step count the last cycle only runs the k==0 step.
                if (k_q == '0) begin
                    r_d     = w_r1;
                    state_d = S_DONE;
                end else begin
                    r_d = reduce_step(w_r1, k_q - KW'(1));
                    if (k_q == KW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = k_q - KW'(2);
                    end
                end
`else
                r_d = reduce_step(r_q, k_q);
                if (k_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
`endif
                if (state_d == S_DONE) begin
                    dout_d = r_d[W_P-1:0];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = dout_q;

endmodule

`default_nettype wire

// File: doc/fp_final_reduce.md
# fp_final_reduce

Canonical modular reduction stage directly downstream of `L3touint`. It takes the unsigned integer produced from a redundant L3 post-adder result, which can be up to `W_IN` bits wide (several multiples of the field modulus), and returns the unique residue in `[0, MOD)`. It uses multi-cycle restoring shift-subtract with a valid/ready handshake on both sides. It feeds field-element consumers that need canonical values: equality checks, output serialisation and host readback.

## Interface
- `W_IN`, default `LEN_12M_TILDE+L3_CARRY`: input width, matching the `L3touint` output.
- `W_P`, default `254`: modulus bit length; requires `MOD >= 2^(W_P-1)`.
- `MOD`, default `PARAMS_BN254_d0::Mod`: field modulus, `W_P` bits.
- Derived `K = W_IN - W_P`: highest shift amount; `K+1` iterations.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rstn` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: `din` is valid.
- `in_ready` output, 1 bit: block can accept; combinational, `state==IDLE`.
- `din` input, `W_IN` bits: unsigned value to reduce.
- `out_valid` output, 1 bit: `dout` holds a result.
- `out_ready` input, 1 bit: consumer accepts `dout`.
- `dout` output, `W_P` bits: `din mod MOD`.

## Operation
- Internal state:
  - Remainder register `r`, `W_IN+1` bits.
  - Shift counter `k`, `$clog2(K+1)` bits.
  - FSM with states `IDLE`, `RUN`, `DONE`.
- `IDLE`: `in_ready=1`. On `in_valid`: `r<=din`, `k<=K`, go to `RUN`.
- `RUN`, one restoring step per cycle:
  - `t = r - (MOD<<k)`, computed `W_IN+1` bits wide.
  - If `t` is non-negative, `r<=t`.
  - If `k==0`, go to `DONE`; otherwise `k<=k-1`.
- Correctness bound: `r < 2^W_IN <= MOD<<(K+1)`, so after step `k` the invariant `r < MOD<<k` holds, and `r < MOD` after step 0.
- `DONE`:
  - `out_valid=1` and `dout=r[W_P-1:0]`, both held stable.
  - On `out_ready`, go to `IDLE`.
  - `in_valid` is ignored in `DONE` and `RUN`.
- Inputs equal to or above `MOD` multiples reduce fully, e.g. `din=MOD` gives `0`.

## Timing
- Reset values:
  - State `IDLE`, `out_valid=0`, `dout=0`, `r=0`, `k=0`.
  - `in_ready` reads 1 while `rstn` is low.
- Latency: acceptance at edge N puts `out_valid` high after edge N+K+1.
- Handshake: a transfer occurs on an edge where valid and ready are both high. `dout` is registered and changes only on entry to `DONE`.
- Throughput: one result per `K+3` cycles when `out_ready` is tied high. There is no overlap: `in_ready` is low in `RUN` and `DONE`, including the `DONE` cycle in which `out_ready` is high.
- Backpressure: `DONE` holds indefinitely while `out_ready` is low; `dout` and `out_valid` stay constant.
- `rstn` asserted mid-`RUN` or mid-`DONE`: the operation is aborted and the state returns to reset values immediately. No partial result is ever presented.
- `out_ready` high outside `DONE` has no effect.

## Configuration
- `FINAL_REDUCE_UNROLL2_EN` defined:
  - Each `RUN` cycle performs two chained steps, for `k` then `k-1`, and `k` decrements by 2.
  - If `K+1` is odd, the final `RUN` cycle performs only the `k==0` step and never evaluates `k=-1`.
  - Latency becomes `ceil((K+1)/2)` cycles; results are bit-identical.
- Not defined: one step per cycle as described above.

## Test plan
- Minimum and exact-modulus inputs:
  - `din=0` → `dout=0` after K+1 cycles.
  - `din=MOD` → `dout=0`.
  - `din=MOD-1` → `dout=MOD-1`.
- Maximum input: `din=2^W_IN-1` → `dout=(2^W_IN-1)%MOD`. Check that `out_valid` rises exactly K+1 cycles after acceptance; ceil((K+1)/2) with the macro defined.
- Backpressure: `out_ready=0` for 5 cycles in `DONE` → `dout` and `out_valid` unchanged, `in_ready=0`, and a concurrent `in_valid` pulse is ignored. Raising `out_ready` → `IDLE` next cycle.
- Reset mid-`RUN`: drop `rstn` 3 cycles after accepting `din=5*MOD+7` → `out_valid=0`, `dout=0` immediately. A restart with `din=5*MOD+7` → `dout=7`.
- Random: 100000 `din` values driven from a `L3touint` output model, compared against `din%MOD` with a random `out_ready` pattern. Run in both macro configurations; zero mismatches required.
